// File: rtl/seq_detector_param.sv
// seq_detector_param
// Serial pattern detector with a run-time loadable pattern, length and
// overlap mode, plus a saturating match counter.
//
// Ports
//   clk     : single clock, all state changes on its rising edge
//   rst     : asynchronous active-low reset
//   in      : serial data bit, consumed on a rising clk when en=1
//   en      : sample-valid qualifier (0 = no bit consumed, state held)
//   load    : configuration load strobe (has priority over en)
//   pat_in  : pattern to load; pat_in[len-1] is the first-received bit
//   len_in  : pattern length to load (valid 2..MAX_LEN)
//   ovl_in  : mode to load, 1 = overlapping, 0 = non-overlapping
//   out     : Mealy match flag, combinational from in and registered state
//   count   : registered saturating match count
//   cfg_err : registered flag, last loaded len_in was out of range
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               en,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat_in,
    input  logic [4:0]         len_in,
    input  logic               ovl_in,
    output logic               out,
    output logic [CNT_W-1:0]   count,
    output logic               cfg_err
);

    localparam logic [4:0]         LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0]         LEN_RST  = 5'd4;
    localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(4'b1101);
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [MAX_LEN:0]   WIN_ZERO = {(MAX_LEN+1){1'b0}};

    // A length is usable only when it spans at least two bits and fits the history.
    function automatic logic len_valid(input logic [4:0] len);
        return (len >= 5'd2) && (len <= LEN_MAX);
    endfunction

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [4:0]         len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [4:0]         fill_q, fill_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN:0]   window_s;
    logic [MAX_LEN:0]   mask_s;
    logic [MAX_LEN:0]   diff_s;
    logic               fill_ok_s;
    logic               match_s;

    // Match evaluation: compare the newest len bits (history plus the live bit) to the pattern.
    always_comb begin
        window_s = {hist_q, in};
        mask_s   = WIN_ZERO;
        for (int i = 0; i <= MAX_LEN; i++) begin
            if (i < int'(len_q)) begin
                mask_s[i] = 1'b1;
            end else begin
                mask_s[i] = 1'b0;
            end
        end
        diff_s = (window_s ^ {1'b0, pat_q}) & mask_s;
        // Enough bits have arrived once the history plus the live bit covers len.
        fill_ok_s = ({1'b0, fill_q} + 6'd1) >= {1'b0, len_q};
        match_s   = en && !load && !cfg_err_q && len_valid(len_q) && fill_ok_s
                    && (diff_s == WIN_ZERO);
    end

    // Next-state logic: load wins over a sample, otherwise an enabled sample shifts in.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        cfg_err_d = cfg_err_q;
        if (load) begin
            pat_d     = pat_in;
            len_d     = len_in;
            ovl_d     = ovl_in;
            hist_d    = {MAX_LEN{1'b0}};
            fill_d    = 5'd0;
            count_d   = {CNT_W{1'b0}};
            cfg_err_d = !len_valid(len_in);
        end else if (en) begin
            hist_d = window_s[MAX_LEN-1:0];
            // Non-overlapping mode forgets the matched bits by restarting the fill.
            if (match_s && !ovl_q) begin
                fill_d = 5'd0;
            end else if (fill_q < LEN_MAX) begin
                fill_d = fill_q + 5'd1;
            end else begin
                fill_d = fill_q;
            end
            if (match_s && (count_q != CNT_MAX)) begin
                count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // State registers with asynchronous reset to the default 1101 configuration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q     <= PAT_RST;
            len_q     <= LEN_RST;
            ovl_q     <= 1'b0;
            hist_q    <= {MAX_LEN{1'b0}};
            fill_q    <= 5'd0;
            count_q   <= {CNT_W{1'b0}};
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            count_q   <= count_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out     = match_s;
    assign count   = count_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param (MAX_LEN=8, CNT_W=2).
// A driver issues one stimulus per clock and pushes the reference model's
// expected out/count/cfg_err into a queue; a monitor pops and compares on
// every falling edge. The reference model keeps the received bits as a plain
// list and checks the newest len bits against the pattern directly.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_SAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       d_in = 1'b0;
    logic       d_en = 1'b0;
    logic       d_load = 1'b0;
    logic [7:0] d_pat = 8'h00;
    logic [4:0] d_len = 5'd0;
    logic       d_ovl = 1'b0;
    logic             dut_out;
    logic [CNT_W-1:0] dut_count;
    logic             dut_err;

    always #5 clk = ~clk;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in(d_in), .en(d_en), .load(d_load),
        .pat_in(d_pat), .len_in(d_len), .ovl_in(d_ovl),
        .out(dut_out), .count(dut_count), .cfg_err(dut_err)
    );

    typedef struct {
        logic out;
        int   cnt;
        logic err;
        int   tag;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] obs_mask = 32'd0;

    // reference model state
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         m_err;
    bit         m_bits[$];
    int         m_cnt;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pat = 8'h0D;
        m_len = 4;
        m_ovl = 1'b0;
        m_err = 1'b0;
        m_bits.delete();
        m_cnt = 0;
    endtask

    function automatic bit model_out(input bit i, input bit e, input bit l);
        bit b;
        if (l || !e || m_err) return 1'b0;
        if (m_bits.size() + 1 < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (k == m_len - 1) b = i;
            else b = m_bits[m_bits.size() - (m_len - 1) + k];
            if (b != m_pat[m_len-1-k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update(input bit i, input bit e, input bit l, input logic [7:0] p,
                                input logic [4:0] len, input bit o, input bit hit);
        if (l) begin
            m_pat = p;
            m_len = int'(len);
            m_ovl = o;
            m_err = !((len >= 5'd2) && (len <= 5'd8));
            m_bits.delete();
            m_cnt = 0;
        end else if (e) begin
            if (hit && m_cnt < CNT_SAT) m_cnt++;
            if (hit && !m_ovl) m_bits.delete();
            else begin
                m_bits.push_back(i);
                if (m_bits.size() > 16) void'(m_bits.pop_front());
            end
        end
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("out", int'(dut_out), int'(mon_e.out));
            check("count", int'(dut_count), mon_e.cnt);
            check("cfg_err", int'(dut_err), int'(mon_e.err));
            if (dut_out === 1'b1 && mon_e.tag > 0 && mon_e.tag < 32) obs_mask[mon_e.tag] = 1'b1;
        end
    end

    task automatic step(input bit i, input bit e, input bit l, input logic [7:0] p,
                        input logic [4:0] len, input bit o, input int tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst = 1'b1; d_in = i; d_en = e; d_load = l; d_pat = p; d_len = len; d_ovl = o;
        x.out = model_out(i, e, l);
        x.cnt = m_cnt;
        x.err = m_err;
        x.tag = tag;
        sb_q.push_back(x);
        model_update(i, e, l, p, len, o, x.out);
    endtask

    task automatic reset_dut();
        exp_t x;
        @(posedge clk);
        #1;
        rst = 1'b0; d_in = 1'b1; d_en = 1'b1; d_load = 1'b0;
        #1;
        check("rst_out", int'(dut_out), 0);
        check("rst_count", int'(dut_count), 0);
        model_reset();
        x.out = 1'b0; x.cnt = 0; x.err = 1'b0; x.tag = 0;
        sb_q.push_back(x);
        obs_mask = 32'd0;
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [4:0] len, input bit o);
        step(1'b1, 1'b1, 1'b1, p, len, o, 0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 0);
    endtask

    task automatic feed(input logic [15:0] bits, input int n, input bit bubbles);
        for (int k = 0; k < n; k++) begin
            if (bubbles && k > 0) idle();
            step(bits[n-1-k], 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, k + 1);
        end
    endtask

    task automatic expect_stream(input string name, input logic [31:0] mask, input int cnt);
        idle();
        check({name, "_count"}, int'(dut_count), cnt);
        @(negedge clk);
        #1;
        check({name, "_mask"}, int'(obs_mask), int'(mask));
        obs_mask = 32'd0;
    endtask

    initial begin
        int r;
        model_reset();
        reset_dut();

        // defaults: 1101, non-overlapping
        feed(16'b01011010110101, 14, 1'b0);
        expect_stream("dflt", (32'd1 << 7) | (32'd1 << 12), 2);

        // overlapping vs non-overlapping
        load_cfg(8'h0D, 5'd4, 1'b1);
        feed(16'b1101101, 7, 1'b0);
        expect_stream("ovl1", (32'd1 << 4) | (32'd1 << 7), 2);
        load_cfg(8'h0D, 5'd4, 1'b0);
        feed(16'b1101101, 7, 1'b0);
        expect_stream("ovl0", 32'd1 << 4, 1);

        // full-width pattern with en bubbles
        load_cfg(8'hA5, 5'd8, 1'b0);
        feed(16'h00A5, 8, 1'b1);
        expect_stream("bubble", 32'd1 << 8, 1);

        // illegal length disables detection, legal reload recovers
        load_cfg(8'h01, 5'd1, 1'b1);
        idle();
        check("cfg_err_set", int'(dut_err), 1);
        feed(16'($urandom), 12, 1'b0);
        expect_stream("disabled", 32'd0, 0);
        load_cfg(8'h05, 5'd3, 1'b0);
        idle();
        check("cfg_err_clr", int'(dut_err), 0);
        feed(16'b101, 3, 1'b0);
        expect_stream("len3", 32'd1 << 3, 1);

        // saturation and mid-sequence reset
        load_cfg(8'h03, 5'd2, 1'b1);
        feed(16'b111111, 6, 1'b0);
        expect_stream("sat", 32'h7C, 3);
        feed(16'b11, 2, 1'b0);
        expect_stream("sat_hold", 32'h06, 3);
        load_cfg(8'h0D, 5'd4, 1'b0);
        feed(16'b1101, 4, 1'b0);
        expect_stream("pre_rst", 32'd1 << 4, 1);
        feed(16'b11, 2, 1'b0);
        reset_dut();
        feed(16'b011101, 6, 1'b0);
        expect_stream("fresh", 32'd1 << 6, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 199));
            if (r < 1) reset_dut();
            else if (r < 8) load_cfg(8'($urandom), 5'($urandom_range(0, 11)), 1'($urandom));
            else step(1'($urandom), r < 170, 1'b0, 8'h00, 5'd0, 1'b0, 0);
        end

        idle();
        @(negedge clk);
        #1;
        check("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
